// File: rtl/dm_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: geometry defaults,
// sequencer state encoding and requester indices.
package dm_arbiter_pkg;

  localparam int unsigned DM_DEPTH = 256;
  localparam int unsigned DM_AW    = 8;
  localparam int unsigned DM_DW    = 32;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_ARB   = 1'b1;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DBG = 1;

endpackage

// File: rtl/dm_arbiter_if.sv
// Single requester port of the data-memory arbiter: request/grant handshake
// plus registered read-return.
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned DW = DM_DW
) ();

  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the
// loser after every grant so a persistent requester alternates fairly.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o[0] = en_i && req_i[0] && (!req_i[1] || !ptr_q);
    gnt_o[1] = en_i && req_i[1] && (!req_i[0] ||  ptr_q);
    ptr_d    = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory front end: zero-fill sweep after reset, then round-robin
// sharing between CPU (m0) and debug loader (m1) with registered read return.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH          = DM_DEPTH,
  parameter int unsigned AW             = DM_AW,
  parameter int unsigned DW             = DM_DW,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   m0,
  dm_arbiter_if.slave   m1,
  output logic          dm_memWrite,
  output logic [31:0]   dm_addr,
  output logic [DW-1:0] dm_data_in,
  input  logic [DW-1:0] dm_out,
  output logic          init_done
);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          init_done_q, init_done_d;
  logic [1:0]    req, gnt;
  logic          arb_en;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          unused_addr_hi;

  assign req[REQ_CPU] = m0.req;
  assign req[REQ_DBG] = m1.req;
  assign arb_en       = (state_q == ST_ARB) && !rst;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    dm_memWrite = 1'b0;
    dm_addr     = '0;
    dm_data_in  = '0;
    if (state_q == ST_CLEAR) begin
      dm_memWrite = !rst;
      dm_addr     = 32'(clr_cnt_q);
      clr_cnt_d   = clr_cnt_q + 1'b1;
      if (clr_cnt_q == AW'(DEPTH - 1)) begin
        state_d     = ST_ARB;
        init_done_d = 1'b1;
      end
    end else begin
      init_done_d = 1'b1;
      if (gnt[REQ_DBG]) begin
        dm_memWrite = m1.we;
        dm_addr     = 32'(m1.addr[AW-1:0]);
        dm_data_in  = m1.wdata;
      end else if (gnt[REQ_CPU]) begin
        dm_memWrite = m0.we;
        dm_addr     = 32'(m0.addr[AW-1:0]);
        dm_data_in  = m0.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      rvalid_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      rvalid_q[0] <= gnt[REQ_CPU] && !m0.we;
      rvalid_q[1] <= gnt[REQ_DBG] && !m1.we;
      if (gnt[REQ_CPU] && !m0.we) rdata0_q <= dm_out;
      if (gnt[REQ_DBG] && !m1.we) rdata1_q <= dm_out;
    end
  end

  // rvalid is masked by rst so a reset in the return cycle drops the pulse
  assign m0.gnt    = gnt[REQ_CPU];
  assign m1.gnt    = gnt[REQ_DBG];
  assign m0.rvalid = rvalid_q[0] && !rst;
  assign m1.rvalid = rvalid_q[1] && !rst;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
  assign init_done = init_done_q;

  assign unused_addr_hi = ^{m0.addr[31:AW], m1.addr[31:AW]};

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (256 x 32, synchronous write, combinational read).
- Requester 0 is the CPU load/store path; requester 1 is the debug/program loader.
- Out of reset, the block first sweeps the memory to zero. It then shares the memory between the two requesters cycle by cycle, using round-robin when both request.
- Read data is returned registered, with a one-cycle rvalid pulse.

Parameters:
- DEPTH, 256, number of memory words; the clear sweep covers addresses 0..DEPTH-1.
- AW, 8, word-address bits used by the memory (log2 DEPTH).
- DW, 32, data width.
- CLEAR_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = go straight to arbitration.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 access request.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  32  address; only [AW-1:0] reaches memory.
- m0_wdata  in  DW  write data.
- m0_gnt  out  1  access accepted this cycle (combinational).
- m0_rvalid  out  1  registered read data valid (1-cycle pulse).
- m0_rdata  out  DW  registered read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_* for requester 1.
- dm_memWrite  out  1  memory write enable.
- dm_addr  out  32  memory address ({(32-AW){0}, addr[AW-1:0]}).
- dm_data_in  out  DW  memory write data.
- dm_out  in  DW  memory combinational read data.
- init_done  out  1  high once the clear sweep is finished; arbitration is live.

Behaviour:
- Reset (rst=1 at posedge):
  - state <= CLEAR (or ARB if CLEAR_ON_RESET=0); clr_cnt <= 0; rr_ptr <= 0 (m0 has priority).
  - m*_rvalid <= 0; m*_rdata <= 0; init_done <= 0.
  - While rst is high: gnt=0 and dm_memWrite=0.
- Reset mid-operation: same as above. Any pending rvalid is dropped, and an in-progress sweep restarts at address 0.
- State CLEAR:
  - dm_memWrite=1, dm_addr=clr_cnt, dm_data_in=0.
  - Both gnt=0; requests are ignored, not queued.
  - clr_cnt increments each cycle. At clr_cnt==DEPTH-1, the next state is ARB and init_done <= 1.
  - Sweep length: exactly DEPTH cycles after the first cycle with rst low. init_done is first visible at cycle DEPTH+1 after reset release.
- CLEAR_ON_RESET=0: init_done <= 1 on the first posedge with rst low.
- State ARB: grant logic is combinational on req and rr_ptr.
  - Only one requester with req=1: it is granted.
  - Both requesting: grant m(rr_ptr).
  - Neither requesting: no grant, dm_memWrite=0.
  - dm_addr, dm_data_in and dm_memWrite(=we) are muxed from the granted requester. A granted write commits at the same posedge.
  - rr_ptr <= index of the non-granted requester after any grant, so a requester that keeps requesting alternates fairly.
- Read latency:
  - A granted read captures dm_out into mX_rdata at that posedge, and mX_rvalid=1 in the following cycle only.
  - Writes never raise rvalid.
  - mX_rdata holds its value until the next read for that requester.
- Ordering:
  - Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
  - A write by one requester followed by a read of the same address on the next cycle returns the new data.
  - Simultaneous same-address read/write requests are serialised by the arbiter; the order follows rr_ptr.
- Requester rule: hold req/we/addr/wdata stable until gnt. The arbiter tolerates req being withdrawn before grant; nothing is latched.
- Address wrap: addresses at or above DEPTH alias modulo DEPTH. There is no error flag.

Decomposition:
- Shared package: state encoding (ST_CLEAR, ST_ARB), requester index constants (REQ_CPU=0, REQ_DBG=1), and the default DEPTH/AW/DW constants.
- One natural sub-module: rr_arb2. It is a 2-way round-robin grant with pointer update and is reusable for other shared resources.

Test Plan:
- Reset, then hold rst low for 256 cycles with m0_req=1 → m0_gnt=0 throughout; dm_memWrite=1 with addresses 0..255 and data 0; init_done=1 from cycle 257; m0 granted the cycle after.
- After init, m0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 the next cycle → m0_gnt both cycles; m0_rvalid pulses one cycle later with m0_rdata=0xDEADBEEF; memory readback at 0x10 is correct.
- m0 and m1 both hold read requests for 4 cycles, with rr_ptr=0 after reset → grant order m0, m1, m0, m1; each requester gets 2 rvalid pulses with the correct data.
- Same cycle: m0 reads 0x20 and m1 writes 0x5 to 0x20, with rr_ptr=1 → m1 is granted first; m0's read, granted the next cycle, returns 0x5.
- Assert rst mid-sweep at clr_cnt=100 → init_done stays 0; the sweep restarts at 0 and init_done rises 256 cycles after rst falls. Also assert rst the cycle after a granted read → rvalid is suppressed.
- m1 reads addr 0x1_0005 → dm_addr=0x05; data returned from word 5 (alias).
